// File: rtl/chroma_alpha_blend_if.sv
// Pixel stream bundle for chroma_alpha_blend.
// Input side: iValid/oReady handshake, iSOF, iKey, live video (iRed/iGreen/iBlue),
// background image (imVGA_R/G/B) and alpha (iTransparencia).
// Output side: oValid/iReady handshake, oSOF, blended pixel oCn {R,G,B}, and
// oKeyCount (keyed-pixel statistics).
// Modports: slave = the blender, master = the producer/consumer driving it.
interface chroma_alpha_blend_if #(
  parameter int unsigned CW    = 10,
  parameter int unsigned CNT_W = 20
);
  logic             iValid;
  logic             oReady;
  logic             iSOF;
  logic             iKey;
  logic [CW-1:0]    iRed;
  logic [CW-1:0]    iGreen;
  logic [CW-1:0]    iBlue;
  logic [CW-1:0]    imVGA_R;
  logic [CW-1:0]    imVGA_G;
  logic [CW-1:0]    imVGA_B;
  logic [CW-1:0]    iTransparencia;
  logic             oValid;
  logic             iReady;
  logic             oSOF;
  logic [3*CW-1:0]  oCn;
  logic [CNT_W-1:0] oKeyCount;

  modport slave (
    input  iValid, iSOF, iKey, iRed, iGreen, iBlue, imVGA_R, imVGA_G, imVGA_B,
           iTransparencia, iReady,
    output oReady, oValid, oSOF, oCn, oKeyCount
  );

  modport master (
    output iValid, iSOF, iKey, iRed, iGreen, iBlue, imVGA_R, imVGA_G, imVGA_B,
           iTransparencia, iReady,
    input  oReady, oValid, oSOF, oCn, oKeyCount
  );
endinterface

// File: rtl/chroma_alpha_blend.sv
// Three-stage pipelined alpha compositor: Cn = A*Cf + (1-A)*Cb per channel.
//   S1: select Cf (image when keyed, else video), Cb = image, register A (11 bit).
//   S2: per-channel products A*Cf and (1024-A)*Cb.
//   S3: rounded sum >> 10, saturated; drives oCn/oSOF/oValid.
// Ports: iCLK27 (pixel clock), iRST (async active-high reset), bus (slave modport
// of chroma_alpha_blend_if carrying both handshakes, pixel data and oKeyCount).
// Optional feature: define CHROMA_BLEND_STATS_EN to build the keyed-pixel counter
// driving oKeyCount; otherwise oKeyCount is tied to 0.
module chroma_alpha_blend #(
  parameter int unsigned CW    = 10,
  parameter int unsigned CNT_W = 20
) (
  input logic                 iCLK27,
  input logic                 iRST,
  chroma_alpha_blend_if.slave bus
);
  localparam int unsigned AW = CW + 1;      // alpha incl. the exact-1.0 code
  localparam int unsigned PW = 2 * CW + 1;  // product width
  localparam int unsigned SW = PW + 1;      // sum width
  localparam int unsigned QW = SW - CW;     // quotient width before saturation
  localparam logic [CW-1:0] CMax  = '1;
  localparam logic [AW-1:0] AOne  = {1'b1, {CW{1'b0}}};
  localparam logic [SW-1:0] Round = {{(SW-CW){1'b0}}, 1'b1, {(CW-1){1'b0}}};

  logic adv, accept;
  logic [CW-1:0] alpha_q, alpha_d;
  logic [AW-1:0] a_in;
  logic [2:0][CW-1:0] vid, img, cf_in;

  logic s1_valid_q, s1_valid_d, s1_sof_q, s1_sof_d;
  logic [2:0][CW-1:0] s1_cf_q, s1_cf_d, s1_cb_q, s1_cb_d;
  logic [AW-1:0] s1_a_q, s1_a_d;

  logic s2_valid_q, s2_valid_d, s2_sof_q, s2_sof_d;
  logic [2:0][PW-1:0] s2_pf_q, s2_pf_d, s2_pb_q, s2_pb_d;

  logic out_valid_q, out_valid_d, out_sof_q, out_sof_d;
  logic [2:0][CW-1:0] out_cn_q, out_cn_d;

  logic [2:0][PW-1:0] pf_c, pb_c;
  logic [2:0][SW-1:0] sum_c;
  logic [2:0][QW-1:0] quo_c;
  logic [2:0][CW-1:0] ch_c;

  // The whole pipeline moves as one; a stalled output freezes every stage.
  assign adv        = bus.iReady | ~out_valid_q;
  assign accept     = bus.iValid & adv;
  assign bus.oReady = adv;

  assign vid   = {bus.iRed, bus.iGreen, bus.iBlue};
  assign img   = {bus.imVGA_R, bus.imVGA_G, bus.imVGA_B};
  assign cf_in = bus.iKey ? img : vid;

  // An SOF beat uses its own alpha, so the effective alpha is the next-state value.
  always_comb begin
    alpha_d = alpha_q;
    if (accept && bus.iSOF) begin
      alpha_d = bus.iTransparencia;
    end
  end

  // Full-scale alpha maps to exactly 1.0 so that Cn == Cf with no rounding loss.
  assign a_in = (alpha_d == CMax) ? AOne : {1'b0, alpha_d};

  always_comb begin
    pf_c  = '0;
    pb_c  = '0;
    sum_c = '0;
    quo_c = '0;
    ch_c  = '0;
    for (int c = 0; c < 3; c++) begin
      pf_c[c]  = {{(PW-AW){1'b0}}, s1_a_q} * {{(PW-CW){1'b0}}, s1_cf_q[c]};
      pb_c[c]  = {{(PW-AW){1'b0}}, AOne - s1_a_q} * {{(PW-CW){1'b0}}, s1_cb_q[c]};
      sum_c[c] = {1'b0, s2_pf_q[c]} + {1'b0, s2_pb_q[c]} + Round;
      quo_c[c] = sum_c[c][SW-1:CW];
      ch_c[c]  = (|quo_c[c][QW-1:CW]) ? CMax : quo_c[c][CW-1:0];
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sof_d    = s1_sof_q;
    s1_cf_d     = s1_cf_q;
    s1_cb_d     = s1_cb_q;
    s1_a_d      = s1_a_q;
    s2_valid_d  = s2_valid_q;
    s2_sof_d    = s2_sof_q;
    s2_pf_d     = s2_pf_q;
    s2_pb_d     = s2_pb_q;
    out_valid_d = out_valid_q;
    out_sof_d   = out_sof_q;
    out_cn_d    = out_cn_q;
    if (adv) begin
      s1_valid_d  = bus.iValid;
      s1_sof_d    = bus.iValid & bus.iSOF;
      s1_cf_d     = cf_in;
      s1_cb_d     = img;
      s1_a_d      = a_in;
      s2_valid_d  = s1_valid_q;
      s2_sof_d    = s1_sof_q;
      s2_pf_d     = pf_c;
      s2_pb_d     = pb_c;
      out_valid_d = s2_valid_q;
      out_sof_d   = s2_sof_q;
      out_cn_d    = ch_c;
    end
  end

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      alpha_q     <= '1;
      s1_valid_q  <= 1'b0;
      s1_sof_q    <= 1'b0;
      s1_cf_q     <= '0;
      s1_cb_q     <= '0;
      s1_a_q      <= '0;
      s2_valid_q  <= 1'b0;
      s2_sof_q    <= 1'b0;
      s2_pf_q     <= '0;
      s2_pb_q     <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_cn_q    <= '0;
    end else begin
      alpha_q     <= alpha_d;
      s1_valid_q  <= s1_valid_d;
      s1_sof_q    <= s1_sof_d;
      s1_cf_q     <= s1_cf_d;
      s1_cb_q     <= s1_cb_d;
      s1_a_q      <= s1_a_d;
      s2_valid_q  <= s2_valid_d;
      s2_sof_q    <= s2_sof_d;
      s2_pf_q     <= s2_pf_d;
      s2_pb_q     <= s2_pb_d;
      out_valid_q <= out_valid_d;
      out_sof_q   <= out_sof_d;
      out_cn_q    <= out_cn_d;
    end
  end

  assign bus.oValid = out_valid_q;
  assign bus.oSOF   = out_sof_q;
  assign bus.oCn    = out_cn_q;

`ifdef CHROMA_BLEND_STATS_EN
  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] cnt_q, cnt_d, key_count_q, key_count_d;

  // An SOF beat closes the previous frame and is itself the first pixel of the next.
  always_comb begin
    cnt_d       = cnt_q;
    key_count_d = key_count_q;
    if (accept) begin
      if (bus.iSOF) begin
        key_count_d = cnt_q;
        cnt_d       = {{(CNT_W-1){1'b0}}, bus.iKey};
      end else if (bus.iKey && (cnt_q != CntMax)) begin
        cnt_d = cnt_q + CntOne;
      end
    end
  end

  always_ff @(posedge iCLK27 or posedge iRST) begin
    if (iRST) begin
      cnt_q       <= '0;
      key_count_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      key_count_q <= key_count_d;
    end
  end

  assign bus.oKeyCount = key_count_q;
`else
  logic [CNT_W-1:0] key_count_zero;
  assign key_count_zero = '0;
  assign bus.oKeyCount  = key_count_zero;
`endif

endmodule

// File: tb/tb_chroma_alpha_blend.sv
// Self-checking bench for chroma_alpha_blend: directed cases plus randomized
// traffic against a queue-based reference model of the blend arithmetic.
module tb_chroma_alpha_blend;
  localparam int CntMax = (1 << 20) - 1;
`ifdef CHROMA_BLEND_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  typedef struct {
    logic        sof;
    logic [29:0] px;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  chroma_alpha_blend_if #(.CW(10), .CNT_W(20)) bus ();
  chroma_alpha_blend #(.CW(10), .CNT_W(20)) dut (.iCLK27(clk), .iRST(rst), .bus(bus));

  int   errors = 0;
  int   checks = 0;
  int   m_alpha, m_cnt, m_kc, cyc;
  bit   lat_chk;
  exp_t q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [29:0] blend(input int alpha, input bit key,
                                        input logic [29:0] vid, input logic [29:0] img);
    int a, f, b, v;
    logic [29:0] cf, res;
    a   = (alpha == 1023) ? 1024 : alpha;
    cf  = key ? img : vid;
    res = '0;
    for (int c = 0; c < 3; c++) begin
      f = int'(cf[c*10 +: 10]);
      b = int'(img[c*10 +: 10]);
      v = (a * f + (1024 - a) * b + 512) / 1024;
      if (v > 1023) v = 1023;
      res[c*10 +: 10] = v[9:0];
    end
    return res;
  endfunction

  function automatic logic [29:0] rgb(input int r, input int g, input int b);
    logic [9:0] rr, gg, bb;
    rr = r[9:0];
    gg = g[9:0];
    bb = b[9:0];
    return {rr, gg, bb};
  endfunction

  function automatic logic [29:0] rand_px();
    return rgb($urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 1023));
  endfunction

  // One clock: drive at negedge, check outputs, update the model, cross the posedge.
  task automatic step(input bit v, input bit sof, input bit key, input logic [9:0] alpha,
                      input logic [29:0] vid, input logic [29:0] img, input bit rdy);
    bit   acc;
    exp_t e;
    bus.iValid         = v;
    bus.iSOF           = sof;
    bus.iKey           = key;
    bus.iTransparencia = alpha;
    {bus.iRed, bus.iGreen, bus.iBlue}          = vid;
    {bus.imVGA_R, bus.imVGA_G, bus.imVGA_B}    = img;
    bus.iReady         = rdy;
    #1;
    check_eq("ready", bus.oReady, (bus.oValid && !rdy) ? 1'b0 : 1'b1);
    if (bus.oValid) begin
      if (q.size() == 0) begin
        check_eq("spurious_valid", bus.oValid, 1'b0);
      end else begin
        check_eq("pixel", bus.oCn, q[0].px);
        check_eq("sof", bus.oSOF, q[0].sof);
        if (rdy) begin
          if (lat_chk) check_eq("latency", cyc - q[0].cyc, 3);
          void'(q.pop_front());
        end
      end
    end
    acc = v && bus.oReady;
    if (acc) begin
      if (sof) begin
        m_alpha = int'(alpha);
        m_kc    = m_cnt;
        m_cnt   = key ? 1 : 0;
      end else if (key && m_cnt < CntMax) begin
        m_cnt++;
      end
      e.sof = sof;
      e.px  = blend(m_alpha, key, vid, img);
      e.cyc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    check_eq("key_count", bus.oKeyCount, StatsOn ? m_kc : 0);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 1'b0, 10'd0, 30'd0, 30'd0, rdy);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && q.size() > 0; i++) idle(1'b1);
    check_eq("drain_empty", q.size(), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check_eq("rst_valid", bus.oValid, 1'b0);
    check_eq("rst_keycount", bus.oKeyCount, 0);
    check_eq("rst_cn", bus.oCn, 0);
    q.delete();
    m_alpha = 1023;
    m_cnt   = 0;
    m_kc    = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    bit keys[10] = '{0, 1, 0, 1, 0, 1, 0, 1, 0, 0};
    logic [29:0] v, im;
    logic [9:0]  al;
    cyc     = 0;
    lat_chk = 1'b0;
    bus.iValid = 1'b0; bus.iSOF = 1'b0; bus.iKey = 1'b0; bus.iReady = 1'b1;
    bus.iTransparencia = '0;
    {bus.iRed, bus.iGreen, bus.iBlue}       = '0;
    {bus.imVGA_R, bus.imVGA_G, bus.imVGA_B} = '0;
    do_reset();

    // Idle after reset release.
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      check_eq("idle_valid", bus.oValid, 1'b0);
      check_eq("idle_cn", bus.oCn, 0);
    end

    // Directed blends with iReady held high; latency checked on delivery.
    lat_chk = 1'b1;
    step(1, 1, 0, 10'd1023, rgb(100, 200, 300), rand_px(), 1);
    drain();
    step(1, 1, 0, 10'd512, rgb(1023, 0, 0), rgb(0, 0, 1023), 1);
    step(1, 0, 1, 10'd77, rand_px(), rgb(40, 80, 120), 1);
    step(1, 0, 0, 10'd5, rgb(9, 500, 1000), rgb(9, 500, 1000), 1);
    drain();
    step(1, 1, 0, 10'd0, rand_px(), rgb(1, 2, 3), 1);
    step(1, 1, 0, 10'd1023, rgb(4, 5, 6), rand_px(), 1);
    drain();
    lat_chk = 1'b0;

    // Stream then stall the output for five cycles while the source keeps offering.
    for (int i = 0; i < 8; i++) step(1, i == 0, 0, 10'd300, rand_px(), rand_px(), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 1, 10'd0, rand_px(), rand_px(), 0);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 10'd0, rand_px(), rand_px(), 1);
    drain();

    // Key statistics over a ten-beat frame with four keyed pixels.
    for (int i = 0; i < 10; i++) step(1, i == 0, keys[i], 10'd700, rand_px(), rand_px(), 1);
    step(1, 1, 0, 10'd300, rand_px(), rand_px(), 1);
    check_eq("frame_keycount", bus.oKeyCount, StatsOn ? 4 : 0);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 10'd0, rand_px(), rand_px(), 1);
    do_reset();
    drain();

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 800; i++) begin
      case ($urandom_range(0, 3))
        0:       al = 10'd0;
        1:       al = 10'd1023;
        2:       al = 10'd512;
        default: al = 10'($urandom_range(0, 1023));
      endcase
      v  = rand_px();
      im = ($urandom_range(0, 7) == 0) ? v : rand_px();
      step($urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 3,
           al, v, im, $urandom_range(0, 3) != 0);
      if (i == 400) do_reset();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
